// File: rtl/rptr_sync_wlevel.sv
// Write-domain receiver for the async FIFO's Gray-coded read pointer.
// Brings rptr across into wclk through a plain flop chain, decodes both
// pointers to binary, and reports a registered fill level, an almost-full
// flag and sticky overflow / pointer-error flags. Writes are never gated
// here; the full condition remains the write-pointer logic's job.
module rptr_sync_wlevel #(
    parameter int ADDRSIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic [ADDRSIZE:0]   rptr,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic                winc,
    input  logic                wfull,
    input  logic                ovf_clr,
    output logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                woverflow,
    output logic                wptr_err
);

    localparam int              DEPTH_INT  = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] DEPTH    = DEPTH_INT[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AF_LEVEL = AF_THRESH[ADDRSIZE:0];

    logic [SYNC_STAGES-1:0][ADDRSIZE:0] syncChain_q;
    logic [ADDRSIZE:0]                  level_q;
    logic [ADDRSIZE:0]                  level_d;
    logic                               almostFull_q;
    logic                               almostFull_d;
    logic                               overflow_q;
    logic                               overflow_d;
    logic                               ptrErr_q;
    logic                               ptrErr_d;
    logic [ADDRSIZE:0]                  rBin;
    logic [ADDRSIZE:0]                  wBin;

    // Gray to binary, MSB first: each binary bit is the XOR of all Gray bits above and including it.
    function automatic logic [ADDRSIZE:0] grayToBin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Synchronizer chain: stage 0 samples the asynchronous rptr, each stage feeds the next untouched.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            syncChain_q <= '0;
        end else begin
            syncChain_q <= {syncChain_q[SYNC_STAGES-2:0], rptr};
        end
    end

    assign wq2_rptr = syncChain_q[SYNC_STAGES-1];
    assign rBin     = grayToBin(wq2_rptr);
    assign wBin     = grayToBin(wptr);

    // Next-state for level and flags; modulo subtraction absorbs pointer wrap, set beats clear on sticky flags.
    always_comb begin
        level_d      = wBin - rBin;
        almostFull_d = (level_d >= AF_LEVEL);
        overflow_d   = overflow_q;
        ptrErr_d     = ptrErr_q;
        if (winc && wfull) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (level_d > DEPTH) begin
            ptrErr_d = 1'b1;
        end else if (ovf_clr) begin
            ptrErr_d = 1'b0;
        end
    end

    // Registered level and status flags, all cleared immediately by reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            level_q      <= '0;
            almostFull_q <= 1'b0;
            overflow_q   <= 1'b0;
            ptrErr_q     <= 1'b0;
        end else begin
            level_q      <= level_d;
            almostFull_q <= almostFull_d;
            overflow_q   <= overflow_d;
            ptrErr_q     <= ptrErr_d;
        end
    end

    assign wlevel       = level_q;
    assign walmost_full = almostFull_q;
    assign woverflow    = overflow_q;
    assign wptr_err     = ptrErr_q;

endmodule

// File: tb/tb_rptr_sync_wlevel.sv
// Bench for rptr_sync_wlevel with default parameters (ADDRSIZE=4, SYNC_STAGES=2, AF_THRESH=12).
// Inputs change and outputs are sampled on the falling edge of wclk.
module tb_rptr_sync_wlevel;

    logic       wclk;
    logic       wrst_n;
    logic [4:0] rptr;
    logic [4:0] wptr;
    logic       winc;
    logic       wfull;
    logic       ovf_clr;
    logic [4:0] wq2_rptr;
    logic [4:0] wlevel;
    logic       walmost_full;
    logic       woverflow;
    logic       wptr_err;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic [4:0] rptr;
        logic [4:0] wptr;
        logic [4:0] expLevel;
        logic       expAf;
        logic       expErr;
    } vec_t;

    typedef struct {
        logic [4:0] wq2;
        logic [4:0] level;
        logic       af;
        logic       ovf;
        logic       err;
    } exp_t;

    vec_t vectors[10];
    exp_t scoreboard[$];

    rptr_sync_wlevel dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .rptr         (rptr),
        .wptr         (wptr),
        .winc         (winc),
        .wfull        (wfull),
        .ovf_clr      (ovf_clr),
        .wq2_rptr     (wq2_rptr),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .woverflow    (woverflow),
        .wptr_err     (wptr_err)
    );

    // Free-running write clock.
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge wclk);
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one table vector, record its expected outputs, and let the pointers settle.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rptr    = v.rptr;
        wptr    = v.wptr;
        winc    = 1'b0;
        wfull   = 1'b0;
        ovf_clr = 1'b1;
        e.wq2   = v.rptr;
        e.level = v.expLevel;
        e.af    = v.expAf;
        e.ovf   = 1'b0;
        e.err   = v.expErr;
        scoreboard.push_back(e);
        tick(4);
    endtask

    // Pop the oldest expectation and compare it against the settled outputs.
    task automatic checkOutput(input string tag);
        exp_t e;
        testsRun++;
        if (scoreboard.size() == 0) begin
            testsFailed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            testsRun--;
            e = scoreboard.pop_front();
            checkValue({tag, " wq2_rptr"}, wq2_rptr, e.wq2);
            checkValue({tag, " wlevel"}, wlevel, e.level);
            checkValue({tag, " walmost_full"}, walmost_full, e.af);
            checkValue({tag, " woverflow"}, woverflow, e.ovf);
            checkValue({tag, " wptr_err"}, wptr_err, e.err);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        vectors[0] = '{5'h00, 5'h0F, 5'd10, 1'b0, 1'b0};
        vectors[1] = '{5'h00, 5'h0E, 5'd11, 1'b0, 1'b0};
        vectors[2] = '{5'h00, 5'h0A, 5'd12, 1'b1, 1'b0};
        vectors[3] = '{5'h00, 5'h18, 5'd16, 1'b1, 1'b0};
        vectors[4] = '{5'h02, 5'h1B, 5'd15, 1'b1, 1'b0};
        vectors[5] = '{5'h00, 5'h19, 5'd17, 1'b1, 1'b1};
        vectors[6] = '{5'h0F, 5'h0F, 5'd0,  1'b0, 1'b0};
        vectors[7] = '{5'h1B, 5'h0F, 5'd24, 1'b1, 1'b1};
        vectors[8] = '{5'h01, 5'h00, 5'd31, 1'b1, 1'b1};
        vectors[9] = '{5'h00, 5'h00, 5'd0,  1'b0, 1'b0};

        // Reset held with live pointers: everything stays zero.
        wrst_n  = 1'b0;
        rptr    = 5'h1B;
        wptr    = 5'h0F;
        winc    = 1'b0;
        wfull   = 1'b0;
        ovf_clr = 1'b0;
        tick(3);
        checkValue("reset wq2_rptr", wq2_rptr, 0);
        checkValue("reset wlevel", wlevel, 0);
        checkValue("reset walmost_full", walmost_full, 0);
        checkValue("reset woverflow", woverflow, 0);
        checkValue("reset wptr_err", wptr_err, 0);

        // Release: level settles to 10 - 18 mod 32 = 24, flagged as corrupt.
        wrst_n = 1'b1;
        tick(3);
        checkValue("release wq2_rptr", wq2_rptr, 5'h1B);
        checkValue("release wlevel", wlevel, 24);
        checkValue("release wptr_err", wptr_err, 1);

        // Latency: settle to empty, then step rptr and watch it arrive.
        rptr    = 5'h00;
        wptr    = 5'h00;
        ovf_clr = 1'b1;
        tick(4);
        ovf_clr = 1'b0;
        checkValue("settle wptr_err", wptr_err, 0);
        rptr = 5'h01;
        tick(1);
        checkValue("latency edge1 wq2_rptr", wq2_rptr, 0);
        tick(1);
        checkValue("latency edge2 wq2_rptr", wq2_rptr, 1);
        checkValue("latency edge2 wlevel", wlevel, 0);
        checkValue("latency edge2 wptr_err", wptr_err, 0);
        tick(1);
        checkValue("latency edge3 wlevel", wlevel, 31);
        checkValue("latency edge3 wptr_err", wptr_err, 1);

        // Table-driven level, threshold and wrap checks.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Pointer error stays set without a clear, then clears with sane pointers.
        ovf_clr = 1'b0;
        rptr    = 5'h00;
        wptr    = 5'h19;
        tick(4);
        checkValue("err set wlevel", wlevel, 17);
        checkValue("err set wptr_err", wptr_err, 1);
        wptr = 5'h00;
        tick(4);
        checkValue("err sticky wlevel", wlevel, 0);
        checkValue("err sticky wptr_err", wptr_err, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checkValue("err clear wptr_err", wptr_err, 0);

        // Overflow set, hold, clear, no-set without wfull, and set-wins.
        winc  = 1'b1;
        wfull = 1'b1;
        tick(1);
        winc  = 1'b0;
        wfull = 1'b0;
        checkValue("ovf set", woverflow, 1);
        tick(1);
        checkValue("ovf hold", woverflow, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        checkValue("ovf clear", woverflow, 0);
        winc = 1'b1;
        tick(1);
        winc = 1'b0;
        checkValue("ovf winc only", woverflow, 0);
        winc    = 1'b1;
        wfull   = 1'b1;
        ovf_clr = 1'b1;
        tick(1);
        winc    = 1'b0;
        wfull   = 1'b0;
        ovf_clr = 1'b0;
        checkValue("ovf set wins", woverflow, 1);

        // Mid-operation reset clears at once, then level recovers.
        wptr = 5'h0F;
        tick(4);
        checkValue("pre-reset wlevel", wlevel, 10);
        #2 wrst_n = 1'b0;
        #1;
        checkValue("async reset wlevel", wlevel, 0);
        checkValue("async reset woverflow", woverflow, 0);
        tick(1);
        wrst_n = 1'b1;
        tick(3);
        checkValue("recover wlevel", wlevel, 10);
        checkValue("recover woverflow", woverflow, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
